// File: rtl/motoro3_step_sequencer.sv
// motoro3 step sequencer: time base and commutation scheduler for the motoro3
// PWM generator. Produces the 12-step index, the intra-step counter and its
// edge strobes, and a soft-start ramped per-step PWM length. Run, stop and
// fault sequencing ensure the generator only ever sees whole, well-formed steps.
module motoro3_step_sequencer #(
  parameter logic [24:0] STEP_LEN_MIN = 25'd64,
  parameter logic [3:0]  STEP_IDX_MAX = 4'd11
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        run_req,
  input  logic        fault,
  input  logic [24:0] stepLenSet,
  input  logic [15:0] pwmLenSet,
  input  logic [15:0] rampInc,
  output logic [3:0]  sgStep,
  output logic [24:0] m3cnt,
  output logic        m3cntFirst1,
  output logic        m3cntFirst2,
  output logic        m3cntLast2,
  output logic        m3cntLast1,
  output logic        pwmActive1,
  output logic [15:0] pwmLENpos,
  output logic        busy,
  output logic        cycleDone,
  output logic        stepLenErr,
  output logic        faultLatched
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_STOPPING} state_t;

  state_t      r_state, w_nextState;
  logic [3:0]  r_sgStep;
  logic [24:0] r_m3cnt;
  logic [24:0] r_L;
  logic [15:0] r_pwmLENpos;
  logic        r_armCnt;
  logic        r_stepLenErr;
  logic        r_faultLatched;

  logic        w_running;
  logic        w_last1;
  logic        w_endCycle;
  logic        w_lenShort;
  logic [24:0] w_lenClamped;

  // Move pwmLENpos toward the target by at most inc; inc==0 means jump.
  function automatic logic [15:0] f_ramp(input logic [15:0] cur,
                                         input logic [15:0] tgt,
                                         input logic [15:0] inc);
    logic [15:0] res;
    if (inc == 16'd0)     res = tgt;
    else if (cur < tgt)   res = ((tgt - cur) > inc) ? cur + inc : tgt;
    else                  res = ((cur - tgt) > inc) ? cur - inc : tgt;
    return res;
  endfunction

  assign w_running    = (r_state == S_RUN) || (r_state == S_STOPPING);
  assign w_last1      = w_running && (r_m3cnt == r_L - 25'd1);
  assign w_endCycle   = w_last1 && (r_sgStep == STEP_IDX_MAX);
  assign w_lenShort   = stepLenSet < STEP_LEN_MIN;
  assign w_lenClamped = w_lenShort ? STEP_LEN_MIN : stepLenSet;

  // State register.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state logic; fault overrides every other transition.
  always_comb begin
    w_nextState = r_state;
    if (fault) begin
      w_nextState = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (run_req && !r_faultLatched) w_nextState = S_ARM;
        S_ARM:      if (r_armCnt) w_nextState = S_RUN;
        S_RUN:      if (!run_req) w_nextState = S_STOPPING;
        S_STOPPING: begin
          if (run_req)         w_nextState = S_RUN;
          else if (w_endCycle) w_nextState = S_IDLE;
        end
        default:    w_nextState = S_IDLE;
      endcase
    end
  end

  // Output decode: strobes only mean something while steps are being issued.
  always_comb begin
    m3cntFirst1 = w_running && (r_m3cnt == 25'd0);
    m3cntFirst2 = w_running && (r_m3cnt == 25'd1);
    m3cntLast2  = w_running && (r_m3cnt == r_L - 25'd2);
    m3cntLast1  = w_last1;
    pwmActive1  = w_running;
    busy        = (r_state != S_IDLE);
    cycleDone   = w_endCycle;
  end

  // Step datapath: counter, step index, step length, ramp and sticky flags.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_sgStep       <= 4'hF;
      r_m3cnt        <= 25'd0;
      r_L            <= STEP_LEN_MIN;
      r_pwmLENpos    <= 16'd0;
      r_armCnt       <= 1'b0;
      r_stepLenErr   <= 1'b0;
      r_faultLatched <= 1'b0;
    end else if (fault) begin
      // stepLenErr is deliberately kept so the cause survives the abort.
      r_sgStep       <= 4'hF;
      r_m3cnt        <= 25'd0;
      r_L            <= STEP_LEN_MIN;
      r_pwmLENpos    <= 16'd0;
      r_armCnt       <= 1'b0;
      r_faultLatched <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_sgStep    <= 4'hF;
          r_m3cnt     <= 25'd0;
          r_pwmLENpos <= 16'd0;
          r_armCnt    <= 1'b0;
          if (r_faultLatched && !run_req) r_faultLatched <= 1'b0;
          if (w_nextState == S_ARM)       r_stepLenErr   <= 1'b0;
        end
        S_ARM: begin
          if (!r_armCnt) begin
            r_armCnt <= 1'b1;
            r_L      <= w_lenClamped;
            if (w_lenShort) r_stepLenErr <= 1'b1;
          end else begin
            r_sgStep    <= 4'd0;
            r_m3cnt     <= 25'd0;
            r_pwmLENpos <= f_ramp(16'd0, pwmLenSet, rampInc);
          end
        end
        default: begin
          if (w_nextState == S_IDLE) begin
            r_sgStep    <= 4'hF;
            r_m3cnt     <= 25'd0;
            r_L         <= STEP_LEN_MIN;
            r_pwmLENpos <= 16'd0;
          end else if (w_last1) begin
            r_m3cnt     <= 25'd0;
            r_sgStep    <= (r_sgStep == STEP_IDX_MAX) ? 4'd0 : r_sgStep + 4'd1;
            r_L         <= w_lenClamped;
            r_pwmLENpos <= f_ramp(r_pwmLENpos, pwmLenSet, rampInc);
            if (w_lenShort) r_stepLenErr <= 1'b1;
          end else begin
            r_m3cnt <= r_m3cnt + 25'd1;
          end
        end
      endcase
    end
  end

  assign sgStep       = r_sgStep;
  assign m3cnt        = r_m3cnt;
  assign pwmLENpos    = r_pwmLENpos;
  assign stepLenErr   = r_stepLenErr;
  assign faultLatched = r_faultLatched;

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Directed table-driven bench for motoro3_step_sequencer.
module tb_motoro3_step_sequencer;

  logic        clk, nRst, run_req, fault;
  logic [24:0] stepLenSet;
  logic [15:0] pwmLenSet, rampInc;
  logic [3:0]  sgStep;
  logic [24:0] m3cnt;
  logic        m3cntFirst1, m3cntFirst2, m3cntLast2, m3cntLast1;
  logic        pwmActive1, busy, cycleDone, stepLenErr, faultLatched;
  logic [15:0] pwmLENpos;

  motoro3_step_sequencer dut (
    .clk(clk), .nRst(nRst), .run_req(run_req), .fault(fault),
    .stepLenSet(stepLenSet), .pwmLenSet(pwmLenSet), .rampInc(rampInc),
    .sgStep(sgStep), .m3cnt(m3cnt),
    .m3cntFirst1(m3cntFirst1), .m3cntFirst2(m3cntFirst2),
    .m3cntLast2(m3cntLast2), .m3cntLast1(m3cntLast1),
    .pwmActive1(pwmActive1), .pwmLENpos(pwmLENpos), .busy(busy),
    .cycleDone(cycleDone), .stepLenErr(stepLenErr), .faultLatched(faultLatched)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // {sg, cnt, F1 F2 L2 L1, act, pwm, busy, cd, err, fl}
  logic [53:0] got;
  assign got = {sgStep, m3cnt, m3cntFirst1, m3cntFirst2, m3cntLast2, m3cntLast1,
                pwmActive1, pwmLENpos, busy, cycleDone, stepLenErr, faultLatched};

  typedef struct {
    logic        run, flt;
    logic [24:0] len;
    logic [15:0] pset, inc;
    int          adv;
    logic [53:0] exp;
  } vec_t;

  vec_t vq[$];
  int   nvec = 0;
  int   nbad = 0;

  localparam logic [3:0] F1 = 4'b1000, F2 = 4'b0100, L2 = 4'b0010, L1 = 4'b0001, NS = 4'b0000;

  function automatic logic [53:0] ex(input logic [3:0] sg, input logic [24:0] cnt,
      input logic [3:0] str, input logic act, input logic [15:0] pwm,
      input logic bsy, input logic cd, input logic err, input logic fl);
    return {sg, cnt, str, act, pwm, bsy, cd, err, fl};
  endfunction

  task automatic add(input logic run, input logic flt, input logic [24:0] len,
      input logic [15:0] pset, input logic [15:0] inc, input int adv, input logic [53:0] e);
    vec_t v;
    v.run = run; v.flt = flt; v.len = len; v.pset = pset; v.inc = inc;
    v.adv = adv; v.exp = e;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [53:0] e);
    nvec++;
    if (got !== e) begin
      nbad++;
      $display("FAIL %s: got sg=%0d cnt=%0d str=%b act=%b pwm=%0d busy=%b cd=%b err=%b fl=%b, exp sg=%0d cnt=%0d str=%b act=%b pwm=%0d busy=%b cd=%b err=%b fl=%b",
        name, got[53:50], got[49:25], got[24:21], got[20], got[19:4], got[3], got[2], got[1], got[0],
        e[53:50], e[49:25], e[24:21], e[20], e[19:4], e[3], e[2], e[1], e[0]);
    end
  endtask

  logic [53:0] idle0;

  initial begin
    idle0 = ex(4'hF, 0, NS, 0, 0, 0, 0, 0, 0);
    nRst = 1'b0; run_req = 0; fault = 0;
    stepLenSet = 25'd100; pwmLenSet = 16'd300; rampInc = 16'd100;

    // Main run: L=100, target 300, ramp 100.
    add(1,0,100,300,100,   1, ex(4'hF, 0, NS,0,  0,1,0,0,0));
    add(1,0,100,300,100,   1, ex(4'hF, 0, NS,0,  0,1,0,0,0));
    add(1,0,100,300,100,   1, ex(0,    0, F1,1,100,1,0,0,0));
    add(1,0,100,300,100,   1, ex(0,    1, F2,1,100,1,0,0,0));
    add(1,0,100,300,100,  97, ex(0,   98, L2,1,100,1,0,0,0));
    add(1,0,100,300,100,   1, ex(0,   99, L1,1,100,1,0,0,0));
    add(1,0,100,300,100,   1, ex(1,    0, F1,1,200,1,0,0,0));
    add(1,0,100,300,100, 100, ex(2,    0, F1,1,300,1,0,0,0));
    add(1,0,100,300,100, 100, ex(3,    0, F1,1,300,1,0,0,0));
    add(1,0,100,300,100, 899, ex(11,  99, L1,1,300,1,1,0,0));
    add(1,0,100,300,100,   1, ex(0,    0, F1,1,300,1,0,0,0));
    add(1,0,100,300,100,1199, ex(11,  99, L1,1,300,1,1,0,0));
    // Drop run_req in step 3: the cycle completes, then IDLE.
    add(1,0,100,300,100, 341, ex(3,   40, NS,1,300,1,0,0,0));
    add(0,0,100,300,100,   1, ex(3,   41, NS,1,300,1,0,0,0));
    add(0,0,100,300,100, 858, ex(11,  99, L1,1,300,1,1,0,0));
    add(0,0,100,300,100,   1, ex(4'hF, 0, NS,0,  0,0,0,0,0));
    add(0,0,100,300,100,   5, ex(4'hF, 0, NS,0,  0,0,0,0,0));
    // Short step request clamps to 64 and sets the sticky error.
    add(1,0, 10,300,  0,   3, ex(0,    0, F1,1,300,1,0,1,0));
    add(1,0, 10,300,  0,  62, ex(0,   62, L2,1,300,1,0,1,0));
    add(1,0, 10,300,  0,   1, ex(0,   63, L1,1,300,1,0,1,0));
    add(1,0, 10,300,  0,   1, ex(1,    0, F1,1,300,1,0,1,0));
    add(1,0,100,300,  0,  64, ex(2,    0, F1,1,300,1,0,1,0));
    add(1,0,100,300,  0,  99, ex(2,   99, L1,1,300,1,0,1,0));
    add(1,0,100,300,  0, 241, ex(5,   40, NS,1,300,1,0,1,0));
    // Fault at step 5 m3cnt 40, then restart rules.
    add(1,1,100,300,  0,   1, ex(4'hF, 0, NS,0,  0,0,0,1,1));
    add(1,0,100,300,  0,  10, ex(4'hF, 0, NS,0,  0,0,0,1,1));
    add(0,0,100,300,  0,   1, ex(4'hF, 0, NS,0,  0,0,0,1,0));
    add(1,0,100,300,100,   1, ex(4'hF, 0, NS,0,  0,1,0,0,0));
    add(1,0,100,300,100,   2, ex(0,    0, F1,1,100,1,0,0,0));
    add(1,0,100,300,100, 200, ex(2,    0, F1,1,300,1,0,0,0));
    // Ramp down 300 -> 50 with inc 100, mid-step change has no effect.
    add(1,0,100, 50,100,  50, ex(2,   50, NS,1,300,1,0,0,0));
    add(1,0,100, 50,100,  50, ex(3,    0, F1,1,200,1,0,0,0));
    add(1,0,100, 50,100, 100, ex(4,    0, F1,1,100,1,0,0,0));
    add(1,0,100, 50,100, 100, ex(5,    0, F1,1, 50,1,0,0,0));
    add(1,0,100, 50,100, 100, ex(6,    0, F1,1, 50,1,0,0,0));
    // rampInc=0 jumps straight to the target at the boundary.
    add(1,0,100,300,  0, 100, ex(7,    0, F1,1,300,1,0,0,0));
    add(1,0,100, 50,  0, 100, ex(8,    0, F1,1, 50,1,0,0,0));

    repeat (3) @(negedge clk);
    nRst = 1'b1;
    // Idle after reset release, run_req low.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle", idle0);
    end

    for (int i = 0; i < vq.size(); i++) begin
      run_req = vq[i].run; fault = vq[i].flt; stepLenSet = vq[i].len;
      pwmLenSet = vq[i].pset; rampInc = vq[i].inc;
      repeat (vq[i].adv) @(posedge clk);
      @(negedge clk);
      check($sformatf("vec[%0d]", i), vq[i].exp);
    end

    // Asynchronous reset mid-run: outputs clear without a clock edge.
    #10 nRst = 1'b0;
    #5 check("async_rst", idle0);
    @(negedge clk);
    run_req = 0; fault = 0;
    nRst = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst", idle0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/motoro3_step_sequencer.md
Name: motoro3_step_sequencer

Overview:
- Time-base and commutation scheduler that drives the motoro3 PWM generator.
- Produces the 12-step commutation index sgStep, the intra-step counter m3cnt, the first/last step strobes and pwmActive1.
- Provides a soft-start ramped per-step PWM length, pwmLENpos.
- Handles run/stop/fault sequencing so the generator only sees whole, well-formed steps.

Parameters:
STEP_LEN_MIN, 25'd64, minimum step length in clk cycles; shorter requests are clamped to it.
STEP_IDX_MAX, 4'd11, last step index of one electrical cycle.

Ports:
clk  in  1  10 MHz system clock; all flops update on the rising edge (the generator samples on the falling edge).
nRst  in  1  reset, asynchronous, active-low.
run_req  in  1  level; 1 = motor run requested.
fault  in  1  level; any cycle high forces an immediate stop.
stepLenSet  in  25  requested step length in clk cycles.
pwmLenSet  in  16  target pwmLENpos.
rampInc  in  16  maximum change of pwmLENpos per step; 0 = jump directly to target.
sgStep  out  4  commutation step 0..11; 15 = idle.
m3cnt  out  25  cycle index within the current step, 0..L-1.
m3cntFirst1  out  1  high when m3cnt==0.
m3cntFirst2  out  1  high when m3cnt==1.
m3cntLast2  out  1  high when m3cnt==L-2.
m3cntLast1  out  1  high when m3cnt==L-1.
pwmActive1  out  1  high only in RUN/STOPPING.
pwmLENpos  out  16  ramped PWM length for the current step.
busy  out  1  high in any state except IDLE.
cycleDone  out  1  one-cycle pulse at m3cntLast1 of step 11.
stepLenErr  out  1  sticky; set when stepLenSet<STEP_LEN_MIN is sampled; cleared on IDLE->ARM.
faultLatched  out  1  set by fault; cleared only when run_req==0 and fault==0.

Behaviour:
- Reset values: sgStep=15; m3cnt=0; all four strobes 0; pwmActive1=0; pwmLENpos=0; busy=0; cycleDone=0; stepLenErr=0; faultLatched=0; state IDLE; L=STEP_LEN_MIN.
- Reset asserted mid-operation returns to the reset values immediately (asynchronous).
- States: IDLE, ARM, RUN, STOPPING.
- IDLE:
  - Outputs held at reset values.
  - run_req==1 && faultLatched==0 -> ARM.
- ARM:
  - Lasts exactly 2 cycles; sgStep=15, pwmActive1=0, pwmLENpos=0.
  - Samples stepLenSet into L in its first cycle.
  - Next cycle enters RUN with sgStep=0, m3cnt=0, m3cntFirst1=1, pwmActive1=1, pwmLENpos=min(rampInc, pwmLenSet), or pwmLenSet if rampInc==0.
- RUN:
  - m3cnt increments by 1 each cycle.
  - At m3cnt==L-1 (Last1): m3cnt->0 and sgStep->sgStep+1, wrapping 11->0.
  - The new L is taken from stepLenSet sampled in the Last1 cycle.
  - pwmLENpos moves toward pwmLenSet by at most rampInc (up or down, no overshoot) in the same cycle the step changes.
  - run_req==0 -> STOPPING; the current step continues uninterrupted.
- STOPPING:
  - Identical to RUN until Last1 of step 11, then IDLE next cycle (sgStep=15, pwmActive1=0, pwmLENpos=0).
  - run_req returning to 1 before that Last1 -> back to RUN with no disturbance to counters.
- Length clamp:
  - Sampled stepLenSet<STEP_LEN_MIN -> L=STEP_LEN_MIN and stepLenErr=1.
  - STEP_LEN_MIN>=4 guarantees the four strobes fall on distinct cycles.
- Fault:
  - fault==1 in any state -> next cycle IDLE, all outputs at reset values except faultLatched=1 and stepLenErr retained. Takes priority over every other transition.
  - No restart while faultLatched==1.
- Change during a step: a pwmLenSet change mid-step does not affect pwmLENpos until the next step boundary.
- cycleDone:
  - Asserted coincident with m3cntLast1 when sgStep==11, in RUN or STOPPING.
  - Not asserted if a fault aborts the step.

Test Plan:
- Reset release, run_req=0 -> sgStep=15, busy=0, all strobes 0 for 100 cycles.
- stepLenSet=100, pwmLenSet=300, rampInc=100, run_req=1:
  - ARM for 2 cycles, then sgStep 0,1,2,... each 100 cycles long.
  - pwmLENpos sequence 100,200,300,300.
  - First1/First2/Last2/Last1 at m3cnt 0/1/98/99.
  - cycleDone once per 1200 cycles.
- stepLenSet=10 -> step length 64 cycles; stepLenErr=1 until the next IDLE->ARM.
- run_req dropped during step 3 -> steps 3..11 complete, then sgStep=15 and pwmActive1=0 one cycle after Last1 of step 11.
- fault pulse during step 5, m3cnt=40 -> next cycle sgStep=15, pwmLENpos=0, faultLatched=1.
  - run_req held high: stays IDLE.
  - run_req low then high: restarts via ARM.
- pwmLenSet lowered 300->50 with rampInc=100 -> pwmLENpos 200, 100, 50 at successive step boundaries; rampInc=0 -> immediate 50 at the next boundary.
